ooe_div_rob_engine: RTL

//  Parametrised out-of-order-execution, in-order-completion integer divider. Accepts dividend/divisor

---
 rtl/ooe_div_pkg.sv | 18 +
 rtl/ooe_div_unit.sv | 89 ++++++++
 rtl/ooe_div_rob_engine.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ooe_div_pkg.sv
// Shared definitions for the out-of-order divider engine: divide-unit state
// encoding and the ROB tag-width helper.
// Optional feature macro used elsewhere in this slice: OOE_DIV_DBZ_FLAG_EN.
package ooe_div_pkg;

  // One-hot unit states; a stray multi-hot value falls back to IDLE.
  typedef enum logic [2:0] {
    UNIT_IDLE = 3'b001,
    UNIT_CALC = 3'b010,
    UNIT_DONE = 3'b100
  } unit_state_e;

  // Number of bits needed to index a ROB of the given depth.
  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ooe_div_unit.sv
// Single restoring-by-subtraction divide unit. Loads an operand pair plus its
// ROB tag on start_i, subtracts once per cycle, then holds the result in DONE
// until the engine acknowledges the writeback.
// With OOE_DIV_DBZ_FLAG_EN defined the divide-by-zero flag is exported.
module ooe_div_unit
  import ooe_div_pkg::*;
#(
  parameter int W  = 8,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [W-1:0]  dividend_i,
  input  logic [W-1:0]  divisor_i,
  input  logic [TW-1:0] tag_i,
  input  logic          ack_i,
  output logic          idle_o,
  output logic          done_o,
  output logic [W-1:0]  quotient_o,
  output logic [W-1:0]  remainder_o,
`ifdef OOE_DIV_DBZ_FLAG_EN
  output logic          dbz_o,
`endif
  output logic [TW-1:0] tag_o
);

  localparam logic [W-1:0] ONE = W'(1);

  unit_state_e   state_q;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [W-1:0]  q_q;
  logic [TW-1:0] tag_q;
  logic          dbz_q;

  // Unit FSM: load on start, one subtract per edge, hold result until acked.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNIT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      tag_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        UNIT_IDLE: begin
          if (start_i) begin
            x_q     <= dividend_i;
            y_q     <= divisor_i;
            q_q     <= '0;
            tag_q   <= tag_i;
            dbz_q   <= (divisor_i == '0);
            state_q <= UNIT_CALC;
          end
        end
        UNIT_CALC: begin
          if (dbz_q) begin
            // Zero divisor: all-ones quotient, dividend left as remainder.
            q_q     <= '1;
            state_q <= UNIT_DONE;
          end else if (x_q >= y_q) begin
            x_q <= x_q - y_q;
            q_q <= q_q + ONE;
          end else begin
            state_q <= UNIT_DONE;
          end
        end
        UNIT_DONE: begin
          if (ack_i) state_q <= UNIT_IDLE;
        end
        default: state_q <= UNIT_IDLE;
      endcase
    end
  end

  assign idle_o      = (state_q == UNIT_IDLE);
  assign done_o      = (state_q == UNIT_DONE);
  assign quotient_o  = q_q;
  assign remainder_o = x_q;
  assign tag_o       = tag_q;
`ifdef OOE_DIV_DBZ_FLAG_EN
  assign dbz_o       = dbz_q;
`endif

endmodule

// File: rtl/ooe_div_rob_engine.sv
// Out-of-order execution, in-order completion integer divider. Requests are
// dispatched to the lowest-index idle unit and tagged with a ROB slot; all
// finished units write back in the same cycle; results leave in accept order.
// Optional feature: OOE_DIV_DBZ_FLAG_EN adds a per-entry divide-by-zero flag
// and the out_dbz port.
module ooe_div_rob_engine
  import ooe_div_pkg::*;
#(
  parameter int W         = 8,
  parameter int N_DIV     = 4,
  parameter int ROB_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_dividend,
  input  logic [W-1:0]                 in_divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_quotient,
  output logic [W-1:0]                 out_remainder,
`ifdef OOE_DIV_DBZ_FLAG_EN
  output logic                         out_dbz,
`endif
  output logic [$clog2(ROB_DEPTH):0]   rob_count
);

  localparam int TW = tag_w(ROB_DEPTH);
  localparam logic [TW:0] PTR_ONE = (TW + 1)'(1);
  localparam logic [TW:0] PTR_FULL = (TW + 1)'(ROB_DEPTH);

  // ROB pointers carry one extra wrap bit so full and empty are distinct.
  logic [TW:0]          wp_q;
  logic [TW:0]          rp_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [W-1:0]         rob_quo [ROB_DEPTH];
  logic [W-1:0]         rob_rem [ROB_DEPTH];
`ifdef OOE_DIV_DBZ_FLAG_EN
  logic                 rob_dbz [ROB_DEPTH];
  logic                 unit_dbz [N_DIV];
`endif

  logic [N_DIV-1:0] unit_idle;
  logic [N_DIV-1:0] unit_done;
  logic [N_DIV-1:0] unit_start;
  logic [W-1:0]     unit_quo [N_DIV];
  logic [W-1:0]     unit_rem [N_DIV];
  logic [TW-1:0]    unit_tag [N_DIV];

  logic [TW-1:0] rp_idx;
  logic          rob_full;
  logic          accept;
  logic          graduate;
  logic          dispatch_taken;

  assign rp_idx    = rp_q[TW-1:0];
  assign rob_count = wp_q - rp_q;
  assign rob_full  = (rob_count == PTR_FULL);

  // Ready depends only on registered state (and reset), never on in_valid.
  assign in_ready  = !rst && !rob_full && (|unit_idle);
  assign accept    = in_valid && in_ready;

  assign out_valid     = !rst && ready_q[rp_idx];
  assign graduate      = out_valid && out_ready;
  assign out_quotient  = out_valid ? rob_quo[rp_idx] : '0;
  assign out_remainder = out_valid ? rob_rem[rp_idx] : '0;
`ifdef OOE_DIV_DBZ_FLAG_EN
  assign out_dbz       = out_valid && rob_dbz[rp_idx];
`endif

  // Dispatch priority encoder: the accepted request goes to the lowest idle unit.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    unit_start     = '0;
    dispatch_taken = 1'b0;
    for (int k = 0; k < N_DIV; k++) begin
      if (accept && unit_idle[k] && !dispatch_taken) begin
        unit_start[k]  = 1'b1;
        dispatch_taken = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_DIV; g++) begin : g_unit
    ooe_div_unit #(
      .W  (W),
      .TW (TW)
    ) u_unit (
      .clk         (clk),
      .rst         (rst),
      .start_i     (unit_start[g]),
      .dividend_i  (in_dividend),
      .divisor_i   (in_divisor),
      .tag_i       (wp_q[TW-1:0]),
      .ack_i       (unit_done[g]),
      .idle_o      (unit_idle[g]),
      .done_o      (unit_done[g]),
      .quotient_o  (unit_quo[g]),
      .remainder_o (unit_rem[g]),
`ifdef OOE_DIV_DBZ_FLAG_EN
      .dbz_o       (unit_dbz[g]),
`endif
      .tag_o       (unit_tag[g])
    );
  end

  // Result storage: every finished unit writes its slot on the same edge.
  // NOTE: the ROB data arrays are not reset; the ready bits alone mark which
  // entries hold valid data, and the output mux forces zero when not valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_DIV; k++) begin
      if (unit_done[k]) begin
        rob_quo[unit_tag[k]] <= unit_quo[k];
        rob_rem[unit_tag[k]] <= unit_rem[k];
`ifdef OOE_DIV_DBZ_FLAG_EN
        rob_dbz[unit_tag[k]] <= unit_dbz[k];
`endif
      end
    end
  end

  // ROB control: pointers advance on accept/graduate, ready bits track completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ready_q <= '0;
    end else begin
      if (accept) wp_q <= wp_q + PTR_ONE;
      if (graduate) begin
        rp_q            <= rp_q + PTR_ONE;
        ready_q[rp_idx] <= 1'b0;
      end
      // A slot being written back is never the head being graduated.
      for (int k = 0; k < N_DIV; k++) begin
        if (unit_done[k]) ready_q[unit_tag[k]] <= 1'b1;
      end
    end
  end

endmodule
